// File: rtl/prism_pkg.sv
// rtl/prism_pkg.sv - shared SIT debug addresses and boot sequencer state encoding
package prism_pkg;

  localparam logic [5:0] SIT_LO_ADDR = 6'h10;
  localparam logic [5:0] SIT_HI_ADDR = 6'h14;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_WR_LO    = 3'd2,
    ST_WAIT_LO  = 3'd3,
    ST_FETCH_HI = 3'd4,
    ST_WR_HI    = 3'd5,
    ST_WAIT_HI  = 3'd6,
    ST_DONE     = 3'd7
  } boot_state_e;

endpackage

// File: rtl/prism_sit_src_timer.sv
// rtl/prism_sit_src_timer.sv - loadable down-counter flagging a stalled source fetch
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      reload counter to 2**TMO_BITS-1 (held while not fetching)
//   en_i        count one cycle spent waiting for the source
//   expire_o    this waiting cycle is the last one allowed
module prism_sit_src_timer #(
  parameter int TMO_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TMO_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '1;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Loaded with 2**TMO_BITS-1, so a value of 1 marks the final waiting cycle.
  assign expire_o = en_i && !load_i && (cnt_q == TMO_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prism_sit_boot_sequencer.sv
// rtl/prism_sit_boot_sequencer.sv - bulk SIT loader and debug-port arbiter
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   boot_start                    start a bulk load (IDLE only)
//   src_req/src_valid/src_data    32-bit word source handshake
//   host_addr/host_wr/host_wdata  host debug bus request
//   host_rdata/host_stall         host read data, write-not-accepted flag
//   sit_addr/sit_wr/sit_wdata     debug port towards the SIT
//   sit_rdata                     debug read data from the SIT
//   cfg_busy                      latch loader shifting
//   load_busy/load_done/load_err  bulk load status
module prism_sit_boot_sequencer
  import prism_pkg::*;
#(
  parameter int WIDTH    = 80,
  parameter int DEPTH    = 2,
  parameter int TMO_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_start,
  output logic        src_req,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  input  logic [5:0]  host_addr,
  input  logic        host_wr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_stall,
  output logic [5:0]  sit_addr,
  output logic        sit_wr,
  output logic [31:0] sit_wdata,
  input  logic [31:0] sit_rdata,
  input  logic        cfg_busy,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int CW = $clog2(DEPTH + 1);
  // The hi word carries the entry bits above 32; unused upper bits are zeroed.
  localparam int          HI_BITS = (WIDTH - 32 > 32) ? 32 : WIDTH - 32;
  localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF >> (32 - HI_BITS);

  boot_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;
  logic          err_q, err_d;
  logic          in_fetch, tmo_expire, lohi_addr;

  assign in_fetch   = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);
  assign lohi_addr  = (host_addr == SIT_LO_ADDR) || (host_addr == SIT_HI_ADDR);
  assign host_rdata = sit_rdata;
  assign load_err   = err_q;

  prism_sit_src_timer #(
    .TMO_BITS (TMO_BITS)
  ) u_src_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (!in_fetch),
    .en_i     (in_fetch && !src_valid),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    err_d      = err_q;
    src_req    = 1'b0;
    sit_addr   = host_addr;
    sit_wdata  = host_wdata;
    sit_wr     = 1'b0;
    host_stall = 1'b0;
    load_busy  = 1'b1;
    load_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_busy  = 1'b0;
        // Host owns the port; only lo/hi writes must respect the loader.
        host_stall = host_wr && lohi_addr && cfg_busy;
        sit_wr     = host_wr && !host_stall;
        if (boot_start) begin
          state_d = ST_FETCH_LO;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH_LO, ST_FETCH_HI: begin
        src_req    = 1'b1;
        host_stall = host_wr;
        if (src_valid) begin
          word_d  = (state_q == ST_FETCH_HI) ? (src_data & HI_MASK) : src_data;
          state_d = (state_q == ST_FETCH_HI) ? ST_WR_HI : ST_WR_LO;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_LO, ST_WR_HI: begin
        host_stall = host_wr;
        sit_addr   = (state_q == ST_WR_HI) ? SIT_HI_ADDR : SIT_LO_ADDR;
        sit_wdata  = word_q;
        if (!cfg_busy) begin
          sit_wr  = 1'b1;
          state_d = (state_q == ST_WR_HI) ? ST_WAIT_HI : ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        host_stall = host_wr;
        if (!cfg_busy) begin
          state_d = ST_FETCH_HI;
        end
      end
      ST_WAIT_HI: begin
        host_stall = host_wr;
        if (!cfg_busy) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == CW'(DEPTH)) ? ST_DONE : ST_FETCH_LO;
        end
      end
      ST_DONE: begin
        host_stall = host_wr;
        load_done  = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prism_sit_boot_sequencer.sv
// tb/tb_prism_sit_boot_sequencer.sv - randomized self-checking bench for the SIT boot sequencer
module tb_prism_sit_boot_sequencer;

  localparam int WIDTH    = 80;
  localparam int DEPTH    = 2;
  localparam int TMO_BITS = 8;
  localparam int TMO      = (1 << TMO_BITS) - 1;

  logic        clk = 1'b0;
  logic        rst_n, boot_start, src_valid, host_wr, cfg_busy;
  logic [31:0] src_data, host_wdata, host_rdata, sit_wdata, sit_rdata;
  logic [5:0]  host_addr, sit_addr;
  logic        src_req, host_stall, sit_wr, load_busy, load_done, load_err;

  prism_sit_boot_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_BITS(TMO_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start),
    .src_req(src_req), .src_valid(src_valid), .src_data(src_data),
    .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_stall(host_stall),
    .sit_addr(sit_addr), .sit_wr(sit_wr), .sit_wdata(sit_wdata), .sit_rdata(sit_rdata),
    .cfg_busy(cfg_busy), .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SIT memory, word source, loader busy model and write recorder
  logic [31:0] sit_mem [64];
  assign sit_rdata = sit_mem[sit_addr];

  logic [31:0] src_words[$];
  logic [37:0] exp_q[$];
  logic [37:0] wr_q[$];
  int src_idx = 0, valid_pct = 100, busy_len = 0, busy_left = 0;
  bit busy_pend = 0, chk_lat = 0;
  int cyc = 0, consume_cyc = 0, done_cnt = 0, done_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (busy_pend) begin
      busy_left = busy_len;
      busy_pend = 0;
    end
    cfg_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    src_valid = rst_n && src_req && (src_idx < src_words.size()) &&
                ($urandom_range(99) < valid_pct);
    src_data  = src_valid ? src_words[src_idx] : $urandom;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (src_req && src_valid) begin
        src_idx++;
        consume_cyc = cyc;
      end
      if (sit_wr) begin
        sit_mem[sit_addr] = sit_wdata;
        if (sit_addr == 6'h10 || sit_addr == 6'h14) begin
          check_eq("lohi_wr_while_busy", cfg_busy, 1'b0);
          if (busy_len > 0) busy_pend = 1;
        end
        if (load_busy) begin
          wr_q.push_back({sit_addr, sit_wdata});
          if (chk_lat) check_eq("src_to_wr_latency", cyc - consume_cyc, 1);
        end
      end
      if (load_done) done_cnt++;
    end
  end

  task automatic prep_load(input int vpct, input int blen, input bit lat);
    int hb;
    logic [63:0] m;
    logic [31:0] lo, hi;
    hb = WIDTH - 32;
    if (hb > 32) hb = 32;
    m = (64'd1 << hb) - 64'd1;
    valid_pct = vpct; busy_len = blen; chk_lat = lat;
    src_words.delete(); exp_q.delete(); wr_q.delete();
    src_idx = 0; done_base = done_cnt;
    for (int e = 0; e < DEPTH; e++) begin
      lo = $urandom; hi = $urandom;
      src_words.push_back(lo); src_words.push_back(hi);
      exp_q.push_back({6'h10, lo});
      exp_q.push_back({6'h14, hi & m[31:0]});
    end
  endtask

  task automatic pulse_boot();
    @(posedge clk); #1 boot_start = 1'b1;
    @(posedge clk); #1 boot_start = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    for (int n = 0; n < 4000 && done_cnt == done_base; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_once"}, done_cnt - done_base, 1);
    check_eq({tag, "_busy_after"}, load_busy, 1'b0);
    check_eq({tag, "_err_after"}, load_err, 1'b0);
    check_eq({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    @(posedge clk); #1;
    host_addr = a; host_wdata = d; host_wr = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!host_stall) break;
      stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic host_release();
    @(posedge clk); #1 host_wr = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st;
    logic [31:0] hd;
    for (int i = 0; i < 64; i++) sit_mem[i] = '0;
    rst_n = 0; boot_start = 0; host_wr = 0; host_addr = '0; host_wdata = '0;
    src_valid = 0; src_data = '0; cfg_busy = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {src_req, host_stall, sit_wr, load_busy, load_done, load_err, sit_addr}, 0);
    check_eq("reset_data", {sit_wdata, host_rdata}, 0);
    @(posedge clk); #1 rst_n = 1;

    // 1: source always valid, no busy
    prep_load(100, 0, 1);
    pulse_boot();
    finish_load("t1");

    // 2: busy held three cycles after every lo/hi write, gappy source
    prep_load(70, 3, 0);
    pulse_boot();
    finish_load("t2");
    host_write(6'h14, 32'h1111_2222, st);
    check_eq("idle_first_wr_stalls", st, 0);
    host_write(6'h10, 32'h3333_4444, st);
    check_eq("idle_busy_stall_cycles", st, 3);
    check_eq("idle_stalled_wr_lands", {sit_wr, sit_addr}, {1'b1, 6'h10});
    host_release();
    repeat (5) @(posedge clk);

    // 3: source never valid -> timeout, then recovery
    prep_load(0, 0, 0);
    pulse_boot();
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (load_err) break;
      @(posedge clk);
    end
    check_eq("tmo_cycles", n, TMO);
    check_eq("tmo_idle", {load_busy, src_req}, 2'b00);
    check_eq("tmo_no_done", done_cnt - done_base, 0);
    prep_load(100, 0, 1);
    pulse_boot();
    @(negedge clk);
    check_eq("err_cleared", load_err, 1'b0);
    finish_load("t3");

    // 4: host write to lo address during load
    prep_load(100, 0, 0);
    pulse_boot();
    hd = $urandom;
    host_write(6'h10, hd, st);
    check_eq("host_stall_seen", st > 0, 1'b1);
    check_eq("host_wr_after_load", {load_busy, 8'(done_cnt - done_base)}, {1'b0, 8'd1});
    check_eq("host_wr_issued", {sit_wr, sit_addr, sit_wdata}, {1'b1, 6'h10, hd});
    host_release();
    host_addr = 6'h10;
    @(negedge clk);
    check_eq("host_readback", host_rdata, hd);
    finish_load("t4");
    host_addr = '0;

    // 5: reset while in WAIT_HI
    prep_load(100, 3, 0);
    pulse_boot();
    for (n = 0; n < 2000 && wr_q.size() < 2; n++) @(negedge clk);
    @(posedge clk); #1;
    check_eq("pre_reset_busy", load_busy, 1'b1);
    rst_n = 0;
    #1;
    check_eq("midreset_ctrl", {src_req, host_stall, sit_wr, load_busy, load_done, load_err, sit_addr}, 0);
    check_eq("midreset_data", {sit_wdata, host_rdata}, 0);
    repeat (3) @(posedge clk);
    check_eq("midreset_no_done", done_cnt - done_base, 0);
    @(posedge clk); #1 rst_n = 1;
    src_words.delete(); wr_q.delete();
    hd = $urandom;
    host_write(6'h08, hd, st);
    check_eq("post_reset_host_wr", {sit_wr, host_stall, sit_addr, sit_wdata}, {2'b10, 6'h08, hd});
    host_release();
    repeat (5) @(posedge clk);

    // 6: boot_start and host write in the same IDLE cycle
    prep_load(100, 0, 0);
    hd = $urandom;
    @(posedge clk); #1;
    boot_start = 1; host_wr = 1; host_addr = 6'h20; host_wdata = hd;
    @(negedge clk);
    check_eq("same_cycle_host_wr", {sit_wr, host_stall, load_busy, sit_addr, sit_wdata}, {3'b100, 6'h20, hd});
    @(posedge clk); #1;
    boot_start = 0; host_wr = 0; host_addr = '0; host_wdata = '0;
    @(negedge clk);
    check_eq("fetch_lo_next", {load_busy, src_req}, 2'b11);
    finish_load("t6");

    // Random loads with a stray boot_start mid-load
    for (int it = 0; it < 4; it++) begin
      prep_load($urandom_range(100, 50), $urandom_range(4, 0), 0);
      pulse_boot();
      repeat (3) @(posedge clk);
      pulse_boot();
      finish_load($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
